// File: rtl/mm_sched_pkg.sv
// Shared state encoding, default sizing and width helper for the matrix-multiplier scheduler.
package mm_sched_pkg;

    localparam int N_DEF          = 32;
    localparam int Q_DEF          = 18;
    localparam int NREQ_DEF       = 4;
    localparam int MM_LATENCY_DEF = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sched_state_e;

    // A 4x4 matrix of N-bit elements, flattened.
    function automatic int mat_w(input int n);
        return 16 * n;
    endfunction

endpackage

// File: rtl/mm_sched_rr_arbiter.sv
// Combinational one-hot round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // NOTE: every variable written here gets a default first, otherwise the
    // paths that skip an assignment would infer a latch.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        found   = 1'b0;
        cand    = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = IDX_W'((int'(ptr_i) + off) % NREQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/mm_scheduler.sv
// Time-shares one 4x4 sequential matrix multiplier between NREQ requesters, round-robin.
// Optional MM_SCHED_STATS_EN adds op_count (wrapping) and abort_count (saturating) outputs.
module mm_scheduler
    import mm_sched_pkg::*;
#(
    parameter  int N          = N_DEF,
    parameter  int Q          = Q_DEF,
    parameter  int NREQ       = NREQ_DEF,
    parameter  int MM_LATENCY = MM_LATENCY_DEF,
    localparam int MAT_W      = mat_w(N),
    localparam int IDX_W      = $clog2(NREQ),
    localparam int CNT_W      = $clog2(MM_LATENCY)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*MAT_W-1:0] req_a,
    input  logic [NREQ*MAT_W-1:0] req_b,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic [MAT_W-1:0]      result,
    output logic                  busy,
    output logic [MAT_W-1:0]      mm_a,
    output logic [MAT_W-1:0]      mm_b,
    output logic                  mm_rst_n,
    input  logic [MAT_W-1:0]      mm_result
`ifdef MM_SCHED_STATS_EN
    ,
    output logic [15:0]           op_count,
    output logic [7:0]            abort_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MM_LATENCY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

    // Q only documents the multiplier's number format; the scheduler never does arithmetic.
    if (NREQ < 2 || NREQ > 8 || MM_LATENCY < 2 || Q < 0 || Q >= N) begin : g_param_check
        $error("mm_scheduler: illegal parameter combination");
    end

    sched_state_e     state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic [MAT_W-1:0] result_q, result_d;
    logic [MAT_W-1:0] mm_a_q, mm_a_d;
    logic [MAT_W-1:0] mm_b_q, mm_b_d;
    logic             mm_rst_n_q, mm_rst_n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic [IDX_W-1:0] ptr_next;
    logic [MAT_W-1:0] op_a [NREQ];
    logic [MAT_W-1:0] op_b [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_a[g] = req_a[g*MAT_W +: MAT_W];
        assign op_b[g] = req_b[g*MAT_W +: MAT_W];
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // After a completion or an abort the requester just served drops to lowest priority.
    assign ptr_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        done_d     = '0;
        result_d   = result_q;
        mm_a_d     = mm_a_q;
        mm_b_d     = mm_b_q;
        mm_rst_n_d = mm_rst_n_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_gnt;
                    idx_d   = arb_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                mm_a_d     = op_a[idx_q];
                mm_b_d     = op_b[idx_q];
                mm_rst_n_d = 1'b1;
                cnt_d      = '0;
                state_d    = RUN;
            end
            RUN: begin
                if (!req[idx_q]) begin
                    mm_rst_n_d = 1'b0;
                    grant_d    = '0;
                    ptr_d      = ptr_next;
                    state_d    = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    result_d   = mm_result;
                    done_d     = grant_q;
                    mm_rst_n_d = 1'b0;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                grant_d = '0;
                ptr_d   = ptr_next;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            done_q     <= '0;
            result_q   <= '0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            mm_rst_n_q <= 1'b0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            result_q   <= result_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
            mm_rst_n_q <= mm_rst_n_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign result   = result_q;
    assign busy     = (state_q != IDLE);
    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;
    assign mm_rst_n = mm_rst_n_q;

`ifdef MM_SCHED_STATS_EN
    logic [15:0] op_count_q;
    logic [7:0]  abort_count_q;

    // Leaving RUN for DONE is a completion; leaving RUN straight to IDLE is an abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_count_q    <= '0;
            abort_count_q <= '0;
        end else if (state_q == RUN) begin
            if (state_d == DONE) begin
                op_count_q <= op_count_q + 1'b1;
            end else if (state_d == IDLE && abort_count_q != 8'hFF) begin
                abort_count_q <= abort_count_q + 1'b1;
            end
        end
    end

    assign op_count    = op_count_q;
    assign abort_count = abort_count_q;
`endif

endmodule

// File: tb/tb_mm_scheduler.sv
// Self-checking bench for mm_scheduler with a behavioural multiplier stub and round-robin model.
`timescale 1ns/1ps
module tb_mm_scheduler;

    localparam int N  = 32;
    localparam int Q  = 18;
    localparam int NR = 4;
    localparam int L  = 18;
    localparam int MW = 16 * N;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR*MW-1:0]  req_a, req_b;
    logic [NR-1:0]     grant, done;
    logic [MW-1:0]     result, mm_a, mm_b, mm_result;
    logic              busy, mm_rst_n;
`ifdef MM_SCHED_STATS_EN
    logic [15:0]       op_count;
    logic [7:0]        abort_count;
`endif

    logic [MW-1:0] a_tb [NR];
    logic [MW-1:0] b_tb [NR];

    int total = 0;
    int bad   = 0;

    // Reference model state
    int            m_ptr;
    int            m_ops;
    int            m_aborts;
    logic [MW-1:0] m_result;

    for (genvar g = 0; g < NR; g++) begin : g_pack
        assign req_a[g*MW +: MW] = a_tb[g];
        assign req_b[g*MW +: MW] = b_tb[g];
    end

    mm_scheduler #(.N(N), .Q(Q), .NREQ(NR), .MM_LATENCY(L)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .grant     (grant),
        .done      (done),
        .result    (result),
        .busy      (busy),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_rst_n  (mm_rst_n),
        .mm_result (mm_result)
`ifdef MM_SCHED_STATS_EN
        ,
        .op_count    (op_count),
        .abort_count (abort_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [MW-1:0] mat_mul(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0] c;
        longint        acc;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int k = 0; k < 4; k++)
                    acc += longint'($signed(a[(i*4+k)*N +: N])) * longint'($signed(b[(k*4+j)*N +: N]));
                c[(i*4+j)*N +: N] = N'(acc >>> Q);
            end
        end
        return c;
    endfunction

    // Multiplier stub: only a correct product after exactly L-1 edges out of reset.
    int run_n;
    always @(posedge clk or negedge reset) begin
        if (!reset)        run_n <= 0;
        else if (mm_rst_n) run_n <= run_n + 1;
        else               run_n <= 0;
    end
    always_comb mm_result = (mm_rst_n && run_n == L - 1) ? mat_mul(mm_a, mm_b) : ~mm_a;

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        int            v;
        m = '0;
        for (int e = 0; e < 16; e++) begin
            v = int'($urandom_range(0, 2097151)) - 1048576;
            m[e*N +: N] = v;
        end
        return m;
    endfunction

    function automatic int pick(input logic [NR-1:0] m, input int p);
        for (int o = 0; o < NR; o++)
            if (m[(p + o) % NR]) return (p + o) % NR;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " grant"},    MW'(grant),    '0);
        check({tag, " done"},     MW'(done),     '0);
        check({tag, " result"},   result,        '0);
        check({tag, " busy"},     MW'(busy),     '0);
        check({tag, " mm_a"},     mm_a,          '0);
        check({tag, " mm_b"},     mm_b,          '0);
        check({tag, " mm_rst_n"}, MW'(mm_rst_n), '0);
`ifdef MM_SCHED_STATS_EN
        check({tag, " op_count"},    MW'(op_count),    '0);
        check({tag, " abort_count"}, MW'(abort_count), '0);
`endif
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_ops    = 0;
        m_aborts = 0;
        m_result = '0;
    endtask

    task automatic do_reset();
        req   = '0;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        model_reset();
    endtask

    // One complete operation from an idle scheduler; optionally rewrites the
    // winner's operands right after the load edge.
    task automatic serve(input logic [NR-1:0] mask, input bit scramble, input string tag);
        int            w;
        int            hi;
        bit            seen;
        logic [NR-1:0] oh;
        logic [MW-1:0] exp;
        w = pick(mask, m_ptr);
        oh = '0;
        oh[w] = 1'b1;
        exp = mat_mul(a_tb[w], b_tb[w]);
        req = mask;
        tick();
        check({tag, " grant"}, MW'(grant), MW'(oh));
        check({tag, " busy"},  MW'(busy),  MW'(1'b1));
        hi = 0;
        seen = 1'b0;
        for (int k = 1; k <= L + 4 && !seen; k++) begin
            tick();
            if (k == 1 && scramble) begin
                a_tb[w] = rand_mat();
                b_tb[w] = rand_mat();
            end
            if (mm_rst_n) hi++;
            if (done != '0) begin
                seen = 1'b1;
                check({tag, " latency"}, MW'(k),   MW'(L + 1));
                check({tag, " done"},    MW'(done), MW'(oh));
                check({tag, " result"},  result,    exp);
            end
        end
        check({tag, " done seen"},   MW'(seen), MW'(1'b1));
        check({tag, " mm_rst_n hi"}, MW'(hi),   MW'(L));
        req = mask & ~oh;
        tick();
        check({tag, " done clear"},  MW'(done),  '0);
        check({tag, " grant clear"}, MW'(grant), '0);
        check({tag, " idle"},        MW'(busy),  '0);
        m_ptr = (w + 1) % NR;
        m_ops++;
        m_result = exp;
        req = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            w, cyc, last, n;
        logic [NR-1:0] oh;
        logic [MW-1:0] ramp, ident;

        for (int i = 0; i < NR; i++) begin
            a_tb[i] = '0;
            b_tb[i] = '0;
        end
        req   = '0;
        reset = 1'b0;
        repeat (2) tick();
        check_reset_state("por");
        reset = 1'b1;
        model_reset();

        // Single request: identity times ramp
        ident = '0;
        ramp  = '0;
        for (int e = 0; e < 16; e++) begin
            ramp[e*N +: N] = N'(e + 1);
            if (e % 5 == 0) ident[e*N +: N] = N'(1 << Q);
        end
        a_tb[0] = ident;
        b_tb[0] = ramp;
        serve(4'b0001, 1'b0, "t1");
        check("t1 identity product", result, ramp);

        // Operands rewritten after load must not reach the product
        a_tb[2] = rand_mat();
        b_tb[2] = rand_mat();
        serve(4'b0100, 1'b1, "t6");

        // All requesters continuously active from pointer 0
        do_reset();
        for (int i = 0; i < NR; i++) begin
            a_tb[i] = rand_mat();
            b_tb[i] = rand_mat();
        end
        req = '1;
        cyc = 0;
        last = 0;
        n = 0;
        while (n < 5 && cyc < 400) begin
            tick();
            cyc++;
            if (done != '0) begin
                w = pick('1, m_ptr);
                oh = '0;
                oh[w] = 1'b1;
                check("t2 done",   MW'(done),  MW'(oh));
                check("t2 grant",  MW'(grant), MW'(oh));
                check("t2 result", result, mat_mul(a_tb[w], b_tb[w]));
                if (n == 0) check("t2 first latency", MW'(cyc), MW'(L + 2));
                else        check("t2 spacing", MW'(cyc - last), MW'(L + 3));
                m_result = mat_mul(a_tb[w], b_tb[w]);
                last = cyc;
                n++;
                m_ptr = (w + 1) % NR;
                m_ops++;
                a_tb[w] = rand_mat();
                b_tb[w] = rand_mat();
                if (n == 5) req = '0;
            end
        end
        check("t2 done count", MW'(n), MW'(5));
        tick();
        check("t2 idle", MW'(busy), '0);

        // Wrap-around: bring the pointer to 2, then request 0 and 1
        serve(4'b0010, 1'b0, "t3 setup");
        serve(4'b0011, 1'b0, "t3 wrap");
        serve(4'b0011, 1'b0, "t3 next");

        // Abort at cnt=5
        w = pick(4'b0100, m_ptr);
        oh = '0;
        oh[w] = 1'b1;
        req = 4'b0100;
        tick();
        check("t4 grant", MW'(grant), MW'(oh));
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4 no early done", MW'(done), '0);
        end
        check("t4 running", MW'(mm_rst_n), MW'(1'b1));
        req = '0;
        tick();
        check("t4 done",     MW'(done),     '0);
        check("t4 mm_rst_n", MW'(mm_rst_n), '0);
        check("t4 grant",    MW'(grant),    '0);
        check("t4 busy",     MW'(busy),     '0);
        check("t4 result",   result,        m_result);
        m_ptr = (w + 1) % NR;
        m_aborts++;
        tick();
        check("t4 still no done", MW'(done), '0);
`ifdef MM_SCHED_STATS_EN
        check("t4 abort_count", MW'(abort_count), MW'(8'(m_aborts)));
        check("t4 op_count",    MW'(op_count),    MW'(16'(m_ops)));
`endif
        a_tb[1] = rand_mat();
        b_tb[1] = rand_mat();
        serve(4'b0110, 1'b0, "t4 after");

        // Asynchronous reset at cnt=10
        w = pick(4'b1000, m_ptr);
        oh = '0;
        oh[w] = 1'b1;
        req = 4'b1000;
        tick();
        check("t5 grant", MW'(grant), MW'(oh));
        tick();
        repeat (10) tick();
        #2 reset = 1'b0;
        #1;
        check_reset_state("t5 async");
        reset = 1'b1;
        req = '0;
        model_reset();
        a_tb[2] = rand_mat();
        b_tb[2] = rand_mat();
        serve(4'b0100, 1'b0, "t5 resume");
        serve(4'b0011, 1'b0, "t5 ptr");
`ifdef MM_SCHED_STATS_EN
        check("t5 op_count",    MW'(op_count),    MW'(16'(m_ops)));
        check("t5 abort_count", MW'(abort_count), MW'(8'(m_aborts)));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
